// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a single outstanding memory
// request, a small fetch queue and optional static JAL prediction.
//
// Configuration macro: FETCH_STATIC_PRED_EN
//   defined   -> JAL responses are predicted taken; fetch continues at target
//   undefined -> sequential fetch only; out_pred_taken tied low
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   pc_en               allow new fetch requests
//   redirect_valid/pc   branch/jump redirect (flushes queue, drops in-flight data)
//   imem_req_*          request channel (valid/ready/addr)
//   imem_rsp_*          response channel (valid/inst)
//   out_*               fetch queue head (valid/ready handshake)
//   fq_count            fetch queue occupancy
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pc_en,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_pc,
  output logic                           imem_req_valid,
  input  logic                           imem_req_ready,
  output logic [XLEN-1:0]                imem_req_addr,
  input  logic                           imem_rsp_valid,
  input  logic [31:0]                    imem_rsp_inst,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [XLEN-1:0]                out_pc,
  output logic [XLEN-1:0]                out_pc_n,
  output logic [31:0]                    out_inst,
  output logic                           out_pred_taken,
  output logic [$clog2(FQ_DEPTH+1)-1:0]  fq_count
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned PW = $clog2(FQ_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] fq_pc   [FQ_DEPTH];
  logic [XLEN-1:0] fq_pc_n [FQ_DEPTH];
  logic [31:0]     fq_inst [FQ_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push, pop;
  logic [XLEN-1:0] seq_pc, next_pc;
  logic            unused_redirect_lsb;

  // Redirect targets are word aligned; the low bits are intentionally dropped.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // rst gating keeps the request channel quiet while reset is held.
  assign imem_req_valid = rst & (state_q == IDLE) & pc_en &
                          (count_q < CW'(FQ_DEPTH)) & ~redirect_valid;
  assign imem_req_addr  = fetch_pc_q;

  assign push   = (state_q == WAIT) & imem_rsp_valid & ~redirect_valid;
  assign pop    = out_valid & out_ready & ~redirect_valid;
  assign seq_pc = req_pc_q + XLEN'(4);

`ifdef FETCH_STATIC_PRED_EN
  logic        rsp_pred;
  logic [20:0] jal_imm;
  logic        fq_pred [FQ_DEPTH];

  assign jal_imm  = {imem_rsp_inst[31], imem_rsp_inst[19:12], imem_rsp_inst[20],
                     imem_rsp_inst[30:21], 1'b0};
  assign rsp_pred = (imem_rsp_inst[6:0] == 7'b1101111);
  assign next_pc  = rsp_pred ? req_pc_q + {{(XLEN-21){jal_imm[20]}}, jal_imm} : seq_pc;
  assign out_pred_taken = fq_pred[rd_ptr_q];

  // Prediction bit storage alongside the queue entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FQ_DEPTH; i++) fq_pred[i] <= 1'b0;
    end else if (push) begin
      fq_pred[wr_ptr_q] <= rsp_pred;
    end
  end
`else
  assign next_pc        = seq_pc;
  assign out_pred_taken = 1'b0;
`endif

  // Next-state and next-fetch-PC; redirect overrides any PC update.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      IDLE: if (imem_req_valid && imem_req_ready) state_d = WAIT;
      WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rsp_valid ? IDLE : DROP;
        end else if (imem_rsp_valid) begin
          state_d    = IDLE;
          fetch_pc_d = next_pc;
        end
      end
      DROP: if (imem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
  end

  // FSM and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (imem_req_valid && imem_req_ready) req_pc_q <= fetch_pc_q;
    end
  end

  // Fetch queue; a redirect flushes it and blocks push/pop that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        fq_pc[i]   <= '0;
        fq_pc_n[i] <= '0;
        fq_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fq_pc[wr_ptr_q]   <= req_pc_q;
        fq_pc_n[wr_ptr_q] <= seq_pc;
        fq_inst[wr_ptr_q] <= imem_rsp_inst;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  assign out_valid = (count_q != '0);
  assign out_pc    = fq_pc[rd_ptr_q];
  assign out_pc_n  = fq_pc_n[rd_ptr_q];
  assign out_inst  = fq_inst[rd_ptr_q];
  assign fq_count  = count_q;

endmodule
